// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and next-PC source encoding for pc_sequencer
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
  localparam int          STEP_DEF       = 4;

  // Where the next PC comes from, listed in decreasing priority.
  typedef enum logic [2:0] {
    EXC   = 3'd0,
    ERET  = 3'd1,
    REDIR = 3'd2,
    HOLD  = 3'd3,
    SEQ   = 3'd4
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack, oldest entry overwritten when full
module pc_ras
  import pc_pkg::*;
#(
  parameter int             N         = 32,
  parameter int             DEPTH     = 4,
  parameter logic [N-1:0]   EMPTY_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  // Next pointer/count; the pointer wraps freely so a push when full lands on the oldest slot.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (en_i) begin
      if (push_i && pop_i) begin
        wr_en = 1'b1;
      end else if (push_i) begin
        ptr_d  = ptr_q + PW'(1);
        wr_idx = ptr_q + PW'(1);
        wr_en  = 1'b1;
        if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
      end else if (pop_i && (cnt_q != '0)) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

  assign top_o   = (cnt_q != '0) ? mem_q[ptr_q] : EMPTY_VAL;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with exception/eret/redirect; PC_RAS_EN adds a return-address stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int           N          = 32,
  parameter logic [N-1:0] RESET_PC   = N'(RESET_PC_DEF),
  parameter logic [N-1:0] EXC_VECTOR = N'(EXC_VECTOR_DEF),
  parameter int           STEP       = STEP_DEF,
  parameter int           RAS_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         exc_req,
  input  logic         eret,
  input  logic         ras_push,
  input  logic         ras_pop,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_next_seq,
  output logic [N-1:0] epc,
  output logic         exc_taken,
  output logic         misaligned
`ifdef PC_RAS_EN
  ,
  output logic [N-1:0] ras_top,
  output logic         ras_empty,
  output logic         ras_full
`endif
);

  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] epc_q, epc_d;
  logic         exc_taken_q, exc_taken_d;
  logic         misaligned_q, misaligned_d;
  pc_src_e      src;
  logic         redir_bad;

  assign pc_next_seq = pc_q + N'(STEP);

  // Pick the next-PC source by fixed priority.
  always_comb begin
    if (exc_req)             src = EXC;
    else if (eret)           src = ERET;
    else if (redirect_valid) src = REDIR;
    else if (stall)          src = HOLD;
    else                     src = SEQ;
  end

  assign redir_bad = (src == REDIR) && (redirect_pc[1:0] != 2'b00);

  // Next-state: a misaligned redirect is folded into the exception path.
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    exc_taken_d  = 1'b0;
    misaligned_d = redir_bad;
    case (src)
      EXC:     pc_d = EXC_VECTOR;
      ERET:    pc_d = epc_q;
      REDIR:   pc_d = redir_bad ? EXC_VECTOR : redirect_pc;
      HOLD:    pc_d = pc_q;
      default: pc_d = pc_next_seq;
    endcase
    if ((src == EXC) || redir_bad) begin
      epc_d       = pc_q;
      exc_taken_d = 1'b1;
    end
  end

  // State registers; reset drops any in-flight event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      epc_q        <= RESET_PC;
      exc_taken_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      exc_taken_q  <= exc_taken_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign exc_taken  = exc_taken_q;
  assign misaligned = misaligned_q;

`ifdef PC_RAS_EN
  logic ras_en;

  // Call/return hints only count on an aligned redirect or a sequential step.
  assign ras_en = ((src == REDIR) && !redir_bad) || (src == SEQ);

  pc_ras #(
    .N         (N),
    .DEPTH     (RAS_DEPTH),
    .EMPTY_VAL (RESET_PC)
  ) u_ras (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (ras_en),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_next_seq),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );
`else
  logic          unused_ras_hints;
  localparam int unused_ras_depth = RAS_DEPTH;
  assign unused_ras_hints = ras_push ^ ras_pop;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (RAS checks when PC_RAS_EN is defined)
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, exc_req, eret, ras_push, ras_pop;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc_next_seq, epc;
  logic        exc_taken, misaligned;
`ifdef PC_RAS_EN
  logic [31:0] ras_top;
  logic        ras_empty, ras_full;
  logic [7:0]  b_ras_top;
  logic        b_ras_empty, b_ras_full;
`endif

  logic        b_redirect_valid;
  logic [7:0]  b_redirect_pc;
  logic [7:0]  b_pc, b_nseq, b_epc;
  logic        b_exc, b_mis;
  logic        tie0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exc;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .eret           (eret),
    .ras_push       (ras_push),
    .ras_pop        (ras_pop),
    .pc             (pc),
    .pc_next_seq    (pc_next_seq),
    .epc            (epc),
    .exc_taken      (exc_taken),
    .misaligned     (misaligned)
`ifdef PC_RAS_EN
    ,
    .ras_top        (ras_top),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full)
`endif
  );

  pc_sequencer #(.N(8), .STEP(4)) dut8 (
    .clk            (clk),
    .reset          (reset),
    .stall          (tie0),
    .redirect_valid (b_redirect_valid),
    .redirect_pc    (b_redirect_pc),
    .exc_req        (tie0),
    .eret           (tie0),
    .ras_push       (tie0),
    .ras_pop        (tie0),
    .pc             (b_pc),
    .pc_next_seq    (b_nseq),
    .epc            (b_epc),
    .exc_taken      (b_exc),
    .misaligned     (b_mis)
`ifdef PC_RAS_EN
    ,
    .ras_top        (b_ras_top),
    .ras_empty      (b_ras_empty),
    .ras_full       (b_ras_full)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
  task automatic step(input string tag, input logic s, input logic rv, input logic [31:0] rpc,
                      input logic ex, input logic er, input logic pu, input logic po,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_exc, input logic e_mis);
    exp_t e;
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    exc_req = ex; eret = er; ras_push = pu; ras_pop = po;
    e.tag = tag; e.pc = e_pc; e.epc = e_epc; e.exc = e_exc; e.mis = e_mis;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".pc"},   pc,                 e.pc);
    check({e.tag, ".nseq"}, pc_next_seq,        e.pc + 32'd4);
    check({e.tag, ".epc"},  epc,                e.epc);
    check({e.tag, ".exc"},  {31'd0, exc_taken}, {31'd0, e.exc});
    check({e.tag, ".mis"},  {31'd0, misaligned},{31'd0, e.mis});
    stall = 0; redirect_valid = 0; exc_req = 0; eret = 0; ras_push = 0; ras_pop = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tie0 = 0;
    reset = 1; stall = 0; redirect_valid = 0; redirect_pc = '0;
    exc_req = 0; eret = 0; ras_push = 0; ras_pop = 0;
    b_redirect_valid = 0; b_redirect_pc = '0;
    #2;
    check("rst.pc",  pc,  32'h0040_0000);
    check("rst.epc", epc, 32'h0040_0000);
    check("rst.exc", {31'd0, exc_taken},  32'd0);
    check("rst.mis", {31'd0, misaligned}, 32'd0);
`ifdef PC_RAS_EN
    check("rst.ras_empty", {31'd0, ras_empty}, 32'd1);
    check("rst.ras_full",  {31'd0, ras_full},  32'd0);
    check("rst.ras_top",   ras_top, 32'h0040_0000);
`endif
    @(negedge clk);
    reset = 0;
    step("seq1", 0,0,0, 0,0,0,0, 32'h0040_0004, 32'h0040_0000, 0,0);
    step("seq2", 0,0,0, 0,0,0,0, 32'h0040_0008, 32'h0040_0000, 0,0);
    step("seq3", 0,0,0, 0,0,0,0, 32'h0040_000C, 32'h0040_0000, 0,0);

    // asynchronous reset in mid-cycle with an exception pending
    exc_req = 1;
    #3;
    reset = 1;
    #1;
    check("areset.pc",  pc,  32'h0040_0000);
    check("areset.epc", epc, 32'h0040_0000);
    check("areset.exc", {31'd0, exc_taken}, 32'd0);
    exc_req = 0;
    @(posedge clk);
    #1;
    check("areset.hold", pc, 32'h0040_0000);
    reset = 0;
    step("post1", 0,0,0, 0,0,0,0, 32'h0040_0004, 32'h0040_0000, 0,0);
    step("post2", 0,0,0, 0,0,0,0, 32'h0040_0008, 32'h0040_0000, 0,0);
    step("post3", 0,0,0, 0,0,0,0, 32'h0040_000C, 32'h0040_0000, 0,0);

    step("stall_redir", 1,1,32'h0040_0100, 0,0,0,0, 32'h0040_0100, 32'h0040_0000, 0,0);
    step("stall",       1,0,0,             0,0,0,0, 32'h0040_0100, 32'h0040_0000, 0,0);
    step("seq4",        0,0,0,             0,0,0,0, 32'h0040_0104, 32'h0040_0000, 0,0);
    step("redir",       0,1,32'h0040_0010, 0,0,0,0, 32'h0040_0010, 32'h0040_0000, 0,0);
    step("misal",       0,1,32'h0040_0102, 0,0,0,0, 32'h8000_0180, 32'h0040_0010, 1,1);
    step("after_misal", 0,0,0,             0,0,0,0, 32'h8000_0184, 32'h0040_0010, 0,0);
    step("redir2",      0,1,32'h0040_0020, 0,0,0,0, 32'h0040_0020, 32'h0040_0010, 0,0);
    step("exc_eret",    0,0,0,             1,1,0,0, 32'h8000_0180, 32'h0040_0020, 1,0);
    step("eret",        0,0,0,             0,1,0,0, 32'h0040_0020, 32'h0040_0020, 0,0);
    step("stall_exc",   1,0,0,             1,0,0,0, 32'h8000_0180, 32'h0040_0020, 1,0);
    step("stall_eret",  1,0,0,             0,1,0,0, 32'h0040_0020, 32'h0040_0020, 0,0);
    step("exc_redir",   0,1,32'h0040_0041, 1,0,0,0, 32'h8000_0180, 32'h0040_0020, 1,0);

    // 8-bit instance: sequential wrap from 0xFC
    b_redirect_valid = 1; b_redirect_pc = 8'hFC;
    @(posedge clk);
    #1;
    b_redirect_valid = 0;
    check("w8.pc",   {24'd0, b_pc},   32'h0000_00FC);
    check("w8.nseq", {24'd0, b_nseq}, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("w8.wrap", {24'd0, b_pc},  32'h0000_0000);
    check("w8.exc",  {31'd0, b_exc}, 32'd0);
    check("w8.mis",  {31'd0, b_mis}, 32'd0);

`ifdef PC_RAS_EN
    step("r_to10", 0,1,32'h10,  0,0,0,0, 32'h10,  32'h0040_0020, 0,0);
    step("push1",  0,1,32'h20,  0,0,1,0, 32'h20,  32'h0040_0020, 0,0);
    check("push1.top",   ras_top, 32'h14);
    check("push1.empty", {31'd0, ras_empty}, 32'd0);
    step("push2",  0,1,32'h30,  0,0,1,0, 32'h30,  32'h0040_0020, 0,0);
    step("push3",  0,1,32'h40,  0,0,1,0, 32'h40,  32'h0040_0020, 0,0);
    step("push4",  0,1,32'h50,  0,0,1,0, 32'h50,  32'h0040_0020, 0,0);
    check("push4.full", {31'd0, ras_full}, 32'd1);
    check("push4.top",  ras_top, 32'h44);
    step("push5",  0,1,32'h100, 0,0,1,0, 32'h100, 32'h0040_0020, 0,0);
    check("push5.full", {31'd0, ras_full}, 32'd1);
    check("push5.top",  ras_top, 32'h54);
    step("pop1",   0,0,0, 0,0,0,1, 32'h104, 32'h0040_0020, 0,0);
    check("pop1.top",  ras_top, 32'h44);
    check("pop1.full", {31'd0, ras_full}, 32'd0);
    step("pop2",   0,0,0, 0,0,0,1, 32'h108, 32'h0040_0020, 0,0);
    check("pop2.top", ras_top, 32'h34);
    step("pop3",   0,0,0, 0,0,0,1, 32'h10C, 32'h0040_0020, 0,0);
    check("pop3.top", ras_top, 32'h24);
    step("pop4",   0,0,0, 0,0,0,1, 32'h110, 32'h0040_0020, 0,0);
    check("pop4.empty", {31'd0, ras_empty}, 32'd1);
    step("pop5",   0,0,0, 0,0,0,1, 32'h114, 32'h0040_0020, 0,0);
    check("pop5.empty", {31'd0, ras_empty}, 32'd1);
    check("pop5.top",   ras_top, 32'h0040_0000);
    step("stall_push", 1,0,0, 0,0,1,0, 32'h114, 32'h0040_0020, 0,0);
    check("stall_push.empty", {31'd0, ras_empty}, 32'd1);
    step("push6",  0,0,0, 0,0,1,0, 32'h118, 32'h0040_0020, 0,0);
    check("push6.top", ras_top, 32'h118);
    step("pushpop", 0,0,0, 0,0,1,1, 32'h11C, 32'h0040_0020, 0,0);
    check("pushpop.top",   ras_top, 32'h11C);
    check("pushpop.empty", {31'd0, ras_empty}, 32'd0);
    step("pop6",   0,0,0, 0,0,0,1, 32'h120, 32'h0040_0020, 0,0);
    check("pop6.empty", {31'd0, ras_empty}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter N, default 32: PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000: PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h8000_0180: exception entry address.
REQ-004 SHALL have parameter STEP, default 4: sequential increment.
REQ-005 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, at least 2.
REQ-006 SHALL have port clk  in  1: single clock, all state updates on posedge.
REQ-007 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-008 SHALL have port stall  in  1: hold PC.
REQ-009 SHALL have ports redirect_valid  in  1 and redirect_pc  in  N: branch/jump target.
REQ-010 SHALL have port exc_req  in  1: take exception.
REQ-011 SHALL have port eret  in  1: return from exception.
REQ-012 SHALL have ports ras_push  in  1 and ras_pop  in  1: call/return hints.
REQ-013 SHALL have ports pc  out  N and pc_next_seq  out  N: current PC and pc+STEP.
REQ-014 SHALL have ports epc  out  N and exc_taken  out  1, a one-cycle pulse.
REQ-015 SHALL have port misaligned  out  1: one-cycle pulse.
REQ-016 SHALL have ports ras_top  out  N, ras_empty  out  1 and ras_full  out  1, present only with PC_RAS_EN.

Function
REQ-017 SHALL select the next PC by priority: exc_req > eret > redirect_valid > stall > sequential.
REQ-018 SHALL set pc<=EXC_VECTOR, epc<=pc, exc_taken=1 on exc_req, even when stall=1.
REQ-019 SHALL set pc<=epc on eret; epc unchanged.
REQ-020 SHALL set pc<=redirect_pc on a redirect whose low 2 bits are 00.
REQ-021 SHALL treat a redirect with nonzero low 2 bits as an exception: pc<=EXC_VECTOR, epc<=pc, misaligned=1, exc_taken=1.
REQ-022 SHALL hold pc on stall=1 with no higher-priority event.
REQ-023 SHALL otherwise set pc<=pc+STEP modulo 2^N; 2^N-STEP wraps to 0 with no flag.
REQ-024 SHALL drive pc_next_seq combinationally as pc+STEP modulo 2^N.
REQ-025 SHALL update every register one cycle after inputs are sampled; latency = 1 clk.
REQ-026 SHALL register exc_taken and misaligned, asserting them in the cycle after the event.

Reset
REQ-027 SHALL drive pc=RESET_PC, epc=RESET_PC, exc_taken=0, misaligned=0, RAS count=0, ras_empty=1, ras_full=0 while reset=1.
REQ-028 SHALL abandon any in-flight exc, eret or redirect on reset mid-operation; the first post-reset edge then follows REQ-017.

Configuration
REQ-029 SHALL, with PC_RAS_EN defined, implement a circular RAS of RAS_DEPTH entries.
REQ-030 SHALL, on push, store pc_next_seq at the new top; when full, overwrite the oldest entry and keep count at RAS_DEPTH.
REQ-031 SHALL, on pop, decrement count; a pop when empty leaves count 0.
REQ-032 SHALL, on simultaneous push and pop, replace the top entry with pc_next_seq and leave count unchanged.
REQ-033 SHALL act on push/pop only in cycles taking the redirect or sequential path; ignore them on stall, exc_req or eret.
REQ-034 SHALL drive ras_top = top entry when count>0, else RESET_PC.
REQ-035 SHALL, without PC_RAS_EN, omit the RAS storage and ras_* ports, ignore ras_push/ras_pop, and otherwise behave identically.

Structure
REQ-036 SHALL take default RESET_PC, EXC_VECTOR and STEP from shared package pc_pkg, which also defines the next-PC-source enumeration (EXC, ERET, REDIR, HOLD, SEQ).
REQ-037 SHALL implement the RAS as sub-module pc_ras, instantiated only under PC_RAS_EN.

Verification
REQ-038 SHALL cover: reset asserted asynchronously mid-cycle -> pc=0x0040_0000 immediately; release, then 3 clk -> pc=0x0040_000C.
REQ-039 SHALL cover: stall=1 with redirect_valid=1, redirect_pc=0x0040_0100 -> pc=0x0040_0100 next clk; stall alone -> pc held.
REQ-040 SHALL cover: redirect_pc=0x0040_0102 at pc=0x0040_0010 -> pc=0x8000_0180, epc=0x0040_0010, misaligned=1 and exc_taken=1 for one cycle.
REQ-041 SHALL cover: exc_req and eret together at pc=0x0040_0020 -> exception wins, epc=0x0040_0020; next cycle eret -> pc=0x0040_0020.
REQ-042 SHALL cover: N=8, STEP=4, pc=0xFC, sequential -> pc=0x00.
REQ-043 SHALL cover, with PC_RAS_EN and RAS_DEPTH=4: 5 pushes at pc 0x10..0x50 -> ras_full=1, ras_top=0x54; 4 pops -> ras_empty=1; 1 more pop -> count 0, ras_top=RESET_PC.
